// File: rtl/ustc_fan_pkg.sv
// Shared definitions for the ustc_fan datapath: ctrl bit positions, slot field layout
// and the FSM state type used by the line packer.
package ustc_fan_pkg;

   localparam int unsigned CTRL_VALID = 3;
   localparam int unsigned CTRL_START = 1;
   localparam int unsigned CTRL_END   = 0;

   typedef enum logic [0:0] {StFill, StHold} fill_state_e;

   // Slot layout is {ctrl, row, data} with data in the low bits.
   function automatic int unsigned row_lsb(input int unsigned dw_data);
      return dw_data;
   endfunction

   function automatic int unsigned ctrl_lsb(input int unsigned dw_data, input int unsigned dw_row);
      return dw_data + dw_row;
   endfunction

   function automatic logic [3:0] make_ctrl(input logic start, input logic last);
      logic [3:0] c;
      c             = '0;
      c[CTRL_VALID] = 1'b1;
      c[CTRL_START] = start;
      c[CTRL_END]   = last;
      return c;
   endfunction

endpackage

// File: rtl/ustc_fan_packer_if.sv
// Element-in / packed-line-out handshake bundle of ustc_fan_packer.
interface ustc_fan_packer_if #(
   parameter int unsigned DW_DATA = 8,
   parameter int unsigned DW_ROW  = 4,
   parameter int unsigned DW_LINE = 16,
   parameter int unsigned NUM_IN  = 32
) ();

   logic                      in_valid;
   logic                      in_ready;
   logic [DW_ROW-1:0]         in_row;
   logic [DW_DATA-1:0]        in_data;
   logic                      in_last;
   logic                      flush;
   logic                      out_valid;
   logic                      out_ready;
   logic [NUM_IN*DW_LINE-1:0] out;

   modport master (
      output in_valid, in_row, in_data, in_last, flush, out_ready,
      input  in_ready, out_valid, out
   );

   modport slave (
      input  in_valid, in_row, in_data, in_last, flush, out_ready,
      output in_ready, out_valid, out
   );

endinterface

// File: rtl/ustc_fan_slot_buf.sv
// Fill buffer of NUM_IN slots with one write port, one set-end port and one read port.
// line_nxt exposes the buffer contents including this cycle's edits.
module ustc_fan_slot_buf #(
   parameter int unsigned NUM_IN  = 32,
   parameter int unsigned DW_LINE = 16,
   parameter int unsigned END_BIT = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [$clog2(NUM_IN)-1:0]  wr_idx,
   input  logic [DW_LINE-1:0]         wr_slot,
   input  logic                       end_en,
   input  logic [$clog2(NUM_IN)-1:0]  end_idx,
   input  logic [$clog2(NUM_IN)-1:0]  rd_idx,
   output logic [DW_LINE-1:0]         rd_slot,
   output logic [NUM_IN*DW_LINE-1:0]  line_nxt
);

   logic [DW_LINE-1:0] slot_q [NUM_IN];
   logic [DW_LINE-1:0] slot_d [NUM_IN];

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         slot_d[i] = slot_q[i];
      end
      if (wr_en) begin
         slot_d[wr_idx] = wr_slot;
      end
      if (end_en) begin
         slot_d[end_idx][END_BIT] = 1'b1;
      end
   end

   always_comb begin
      line_nxt = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         line_nxt[i*DW_LINE +: DW_LINE] = slot_d[i];
      end
   end

   assign rd_slot = slot_q[rd_idx];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < NUM_IN; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_IN; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

endmodule

// File: rtl/ustc_fan_packer.sv
// Packs a serial stream of (row, data) elements into NUM_IN-slot lines with segment
// start/end flags; fill buffer plus output register so filling overlaps a waiting line.
module ustc_fan_packer
   import ustc_fan_pkg::*;
#(
   parameter int unsigned DW_DATA = 8,
   parameter int unsigned DW_ROW  = 4,
   parameter int unsigned DW_CTRL = 4,
   parameter int unsigned NUM_IN  = 32
) (
   input logic              clk,
   input logic              rst,
   ustc_fan_packer_if.slave bus
);

   localparam int unsigned DW_LINE = DW_DATA + DW_ROW + DW_CTRL;
   localparam int unsigned IW      = $clog2(NUM_IN);
   localparam int unsigned CW      = $clog2(NUM_IN + 1);
   localparam int unsigned END_BIT = ctrl_lsb(DW_DATA, DW_ROW) + CTRL_END;

   fill_state_e               state_q, state_d;
   logic [CW-1:0]             count_q, count_d;
   logic [NUM_IN*DW_LINE-1:0] out_q, out_d;
   logic                      out_valid_q, out_valid_d;

   logic [IW-1:0]             wr_idx, prev_idx;
   logic [DW_LINE-1:0]        wr_slot, prev_slot;
   logic [NUM_IN*DW_LINE-1:0] line_nxt;
   logic                      accept, first, newseg, end_en;
   logic                      close_acc, close_flush, close, can_xfer, xfer;

   // Slots fill from NUM_IN-1 downward, so the previous slot sits one index above.
   assign wr_idx   = IW'(NUM_IN - 1) - count_q[IW-1:0];
   assign prev_idx = wr_idx + IW'(1);

   assign bus.in_ready  = (state_q == StFill);
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;

   assign accept      = bus.in_valid && bus.in_ready;
   assign first       = (count_q == '0);
   assign newseg      = first || (bus.in_row != prev_slot[row_lsb(DW_DATA) +: DW_ROW]);
   assign close_acc   = accept && ((count_q == CW'(NUM_IN - 1)) || bus.in_last || bus.flush);
   // A bare flush closes at the last filled slot, which is also prev_idx.
   assign close_flush = (state_q == StFill) && bus.flush && !accept && !first;
   assign close       = close_acc || close_flush;
   assign end_en      = (accept && !first && newseg) || close_flush;
   assign can_xfer    = !out_valid_q || bus.out_ready;
   assign wr_slot     = {DW_CTRL'(make_ctrl(newseg, close_acc)), bus.in_row, bus.in_data};

   ustc_fan_slot_buf #(
      .NUM_IN  (NUM_IN),
      .DW_LINE (DW_LINE),
      .END_BIT (END_BIT)
   ) u_slot_buf (
      .clk      (clk),
      .rst      (rst),
      .clr      (xfer),
      .wr_en    (accept),
      .wr_idx   (wr_idx),
      .wr_slot  (wr_slot),
      .end_en   (end_en),
      .end_idx  (prev_idx),
      .rd_idx   (prev_idx),
      .rd_slot  (prev_slot),
      .line_nxt (line_nxt)
   );

   always_comb begin
      state_d = state_q;
      xfer    = 1'b0;
      unique case (state_q)
         StFill: begin
            if (close) begin
               if (can_xfer) begin
                  xfer = 1'b1;
               end else begin
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (can_xfer) begin
               xfer    = 1'b1;
               state_d = StFill;
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_comb begin
      count_d     = count_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (xfer) begin
         count_d = '0;
      end else if (accept) begin
         count_d = count_q + CW'(1);
      end
      if (xfer) begin
         out_d       = line_nxt;
         out_valid_d = 1'b1;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StFill;
         count_q     <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_ustc_fan_packer.sv
// Directed and randomized bench for ustc_fan_packer against a queue-based line model.
module tb_ustc_fan_packer;

   typedef struct packed {
      logic [3:0] row;
      logic [7:0] data;
   } elem_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ustc_fan_packer_if #(.DW_DATA(8), .DW_ROW(4), .DW_LINE(16), .NUM_IN(8))  b8 ();
   ustc_fan_packer_if #(.DW_DATA(8), .DW_ROW(4), .DW_LINE(16), .NUM_IN(32)) b32 ();

   ustc_fan_packer #(.DW_DATA(8), .DW_ROW(4), .DW_CTRL(4), .NUM_IN(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (b8)
   );

   ustc_fan_packer #(.DW_DATA(8), .DW_ROW(4), .DW_CTRL(4), .NUM_IN(32)) dut32 (
      .clk (clk),
      .rst (rst),
      .bus (b32)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   elem_t       cur[$];
   logic [511:0] exp_q[$];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference line: start/end flags derived by looking at both neighbours in the line.
   function automatic logic [511:0] build_line(input elem_t q[$], input int num);
      logic [511:0] l;
      logic         s, e;
      l = '0;
      for (int j = 0; j < q.size(); j++) begin
         s = 1'b1;
         e = 1'b1;
         if (j > 0) s = (q[j].row != q[j-1].row);
         if (j < q.size() - 1) e = (q[j].row != q[j+1].row);
         l[(num-1-j)*16 +: 16] = {1'b1, 1'b0, s, e, q[j].row, q[j].data};
      end
      return l;
   endfunction

   function automatic logic [31:0] ctrl8(input logic [127:0] l);
      logic [31:0] c;
      c = '0;
      for (int i = 7; i >= 0; i--) c = {c[27:0], l[i*16+12 +: 4]};
      return c;
   endfunction

   task automatic model_close();
      if (cur.size() > 0) begin
         exp_q.push_back(build_line(cur, 8));
         cur.delete();
      end
   endtask

   task automatic step8(input logic v, input logic [3:0] r, input logic [7:0] d,
                        input logic l, input logic f, input logic ordy, output logic acc);
      logic         stall;
      logic [511:0] held;
      elem_t        e;
      b8.in_valid  = v;
      b8.in_row    = r;
      b8.in_data   = d;
      b8.in_last   = l;
      b8.flush     = f;
      b8.out_ready = ordy;
      #1;
      acc   = v && b8.in_ready;
      stall = b8.out_valid && !ordy;
      held  = 512'(b8.out);
      if (b8.out_valid && ordy) begin
         if (exp_q.size() == 0) chk("unexpected_line", 512'(b8.out_valid), 512'(0));
         else chk("drain_line", 512'(b8.out), exp_q.pop_front());
      end
      if (acc) begin
         e.row  = r;
         e.data = d;
         cur.push_back(e);
         if (cur.size() == 8 || l || f) model_close();
      end else if (f) begin
         model_close();
      end
      @(posedge clk);
      #1;
      if (stall) begin
         chk("stall_valid", 512'(b8.out_valid), 512'(1));
         chk("stall_stable", 512'(b8.out), held);
      end
      b8.in_valid = 1'b0;
      b8.in_last  = 1'b0;
      b8.flush    = 1'b0;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      b8.in_valid = 1'b0;
      b8.flush    = 1'b0;
      b8.in_last  = 1'b0;
      cur.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic         acc;
      int           rows1 [8] = '{3, 3, 3, 1, 1, 0, 0, 0};
      int           rows2 [3] = '{2, 2, 5};
      elem_t        cur32[$];
      elem_t        e;
      logic [127:0] c32, all_b;

      b8.in_valid   = 1'b0; b8.in_row  = '0; b8.in_data  = '0;
      b8.in_last    = 1'b0; b8.flush   = 1'b0; b8.out_ready = 1'b1;
      b32.in_valid  = 1'b0; b32.in_row = '0; b32.in_data = '0;
      b32.in_last   = 1'b0; b32.flush  = 1'b0; b32.out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      do_reset();
      chk("rst_out_valid", 512'(b8.out_valid), 512'(0));
      chk("rst_out", 512'(b8.out), 512'(0));
      chk("rst_in_ready", 512'(b8.in_ready), 512'(1));

      // Full line, mixed segments, no stall.
      for (int i = 0; i < 8; i++) begin
         step8(1'b1, 4'(rows1[i]), 8'(i + 1), 1'b0, 1'b0, 1'b1, acc);
         chk("t1_accept", 512'(acc), 512'(1));
         if (i == 6) chk("t1_no_early_valid", 512'(b8.out_valid), 512'(0));
      end
      chk("t1_latency", 512'(b8.out_valid), 512'(1));
      chk("t1_ctrl", 512'(ctrl8(b8.out)), 512'(32'hA89A9A89));

      // Partial line closed by flush.
      step8(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
      for (int i = 0; i < 3; i++) begin
         step8(1'b1, 4'(rows2[i]), 8'(9 + i), 1'b0, 1'b0, 1'b1, acc);
         chk("t2_in_ready", 512'(b8.in_ready), 512'(1));
      end
      step8(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, acc);
      chk("t2_valid", 512'(b8.out_valid), 512'(1));
      chk("t2_ctrl", 512'(ctrl8(b8.out)), 512'(32'hA9B00000));
      chk("t2_in_ready", 512'(b8.in_ready), 512'(1));

      // Segment continues across a line boundary; in_last closes the second line.
      for (int i = 0; i < 10; i++) begin
         step8(1'b1, 4'd4, 8'(20 + i), (i == 9), 1'b0, 1'b1, acc);
         if (i == 7) chk("t3_line_a", 512'(ctrl8(b8.out)), 512'(32'hA8888889));
      end
      chk("t3_line_b", 512'(ctrl8(b8.out)), 512'(32'hA9000000));

      // Back-pressure: second full line parks in HOLD.
      step8(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
      for (int i = 0; i < 16; i++) begin
         step8(1'b1, 4'($urandom_range(0, 3)), 8'($urandom), 1'b0, 1'b0, 1'b0, acc);
         chk("t4_accept", 512'(acc), 512'(1));
      end
      chk("t4_hold_ready", 512'(b8.in_ready), 512'(0));
      chk("t4_out_a", 512'(b8.out), exp_q[0]);
      step8(1'b1, 4'd1, 8'd1, 1'b0, 1'b0, 1'b0, acc);
      chk("t4_hold_no_accept", 512'(acc), 512'(0));
      step8(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
      chk("t4_b_valid", 512'(b8.out_valid), 512'(1));
      chk("t4_out_b", 512'(b8.out), exp_q[0]);
      chk("t4_ready_back", 512'(b8.in_ready), 512'(1));
      step8(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc);

      // Reset in mid-line discards the partial line.
      for (int i = 0; i < 5; i++) step8(1'b1, 4'(i), 8'(40 + i), 1'b0, 1'b0, 1'b1, acc);
      do_reset();
      chk("t5_out_valid", 512'(b8.out_valid), 512'(0));
      chk("t5_out", 512'(b8.out), 512'(0));
      for (int i = 0; i < 3; i++) begin
         step8(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
         chk("t5_no_emit", 512'(b8.out_valid), 512'(0));
      end
      step8(1'b1, 4'd7, 8'h5A, 1'b0, 1'b1, 1'b1, acc);
      chk("t5_single_ctrl", 512'(ctrl8(b8.out)), 512'(32'hB0000000));
      chk("t5_slot7", 512'(b8.out[127:112]), 512'(16'hB75A));
      step8(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, acc);

      // Randomized traffic with random back-pressure.
      for (int i = 0; i < 400; i++) begin
         step8(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 3)), 8'($urandom),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 9) < 6), acc);
      end
      step8(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, acc);
      for (int i = 0; i < 4; i++) step8(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, acc);
      chk("rand_drained", 512'(b8.out_valid), 512'(0));

      // NUM_IN=32, alternating rows: every slot is a single-element segment.
      for (int i = 0; i < 32; i++) begin
         b32.in_valid = 1'b1;
         b32.in_row   = 4'(i % 2);
         b32.in_data  = 8'(i);
         #1;
         if (b32.in_ready) begin
            e.row  = 4'(i % 2);
            e.data = 8'(i);
            cur32.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      b32.in_valid = 1'b0;
      c32 = '0;
      for (int i = 31; i >= 0; i--) c32 = {c32[123:0], b32.out[i*16+12 +: 4]};
      all_b = {32{4'hB}};
      chk("t6_valid", 512'(b32.out_valid), 512'(1));
      chk("t6_ctrl", 512'(c32), 512'(all_b));
      chk("t6_line", 512'(b32.out), build_line(cur32, 32));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ustc_fan_packer.md
Name: ustc_fan_packer

Overview:
- Transmit-side front end for ustc_fan.
- Takes a serial stream of nonzero (row, data) elements and packs them into one NUM_IN-slot line vector, with per-slot ctrl flags marking segment start/end.
- Hands the vector to the FAN input with a valid/ready handshake.
- Double-buffered (fill buffer + output register), so filling continues while a packed line waits downstream.

Parameters:
- DW_DATA, 8, data field width
- DW_ROW, 4, row-index field width
- DW_CTRL, 4, ctrl field width; bit3=valid, bit2=reserved(0), bit1=start, bit0=end
- DW_LINE, DW_DATA+DW_ROW+DW_CTRL, slot width; slot layout {ctrl, row, data}
- NUM_IN, 32, slots per line (power of two, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  element valid
- in_ready  out  1  element accepted when in_valid&&in_ready
- in_row  in  DW_ROW  output row of element
- in_data  in  DW_DATA  element value
- in_last  in  1  final element of batch; forces line close after this element
- flush  in  1  close current partial line (no element attached)
- out_valid  out  1  packed line valid
- out_ready  in  1  downstream accepts line
- out  out  NUM_IN*DW_LINE  packed line; slot i = out[(i+1)*DW_LINE-1 : i*DW_LINE]

Behaviour:
- Reset (synchronous, rst=1 at posedge): fill buffer zeroed, fill count=0, out register zeroed, out_valid=0, in_ready=1 after the reset cycle. Reset mid-line discards both buffers; no partial emission.
- Fill order: first element of a line goes to slot NUM_IN-1, then descending toward slot 0. Unused slots are all-zero (ctrl=0000).
- Ctrl on write: valid=1. start=1 if the slot is the first of the line or in_row != row of the previous slot in this line; otherwise start=0. end=0.
- Retroactive end: when an accepted element starts a new segment (not first in line), the previous slot's end bit is set in the same cycle.
- Line close: the last filled slot gets end=1. Close happens on:
  - accepting the NUM_IN-th element, or
  - accepting an element with in_last=1, or
  - flush=1 with count>0. flush with count=0 is a no-op.
  - flush and an accepted element in the same cycle: the element is included first, then the line closes.
- Continuation: a row segment split across lines starts fresh in the new line (start=1). Downstream accumulates the partial sums.
- Single-element segment: ctrl=1011.
- Transfer to output: a closed line moves into the out register at the same posedge if the out register is empty or is being drained (out_valid&&out_ready). out_valid rises the cycle after close. The fill buffer clears and count resets in the same cycle.
- Stall: if a closed line cannot transfer, it stays in the fill buffer (state HOLD) and in_ready=0 until the transfer happens.
- FSM:
  - FILL: in_ready=1; goes to HOLD on close-without-transfer.
  - HOLD: in_ready=0; goes to FILL when the transfer occurs.
- out is stable while out_valid&&!out_ready.
- Latency: close-causing element accepted in cycle t -> out_valid=1 in t+1.
- Throughput: one element/cycle sustained while out_ready=1.
- Count width is $clog2(NUM_IN+1).
- No arithmetic on data; row compare is full DW_ROW equality.

Decomposition:
- Shared package ustc_fan_pkg:
  - ctrl bit positions CTRL_VALID=3, CTRL_START=1, CTRL_END=0.
  - slot field offsets and pack/unpack functions, reused by ustc_fan and its collector.
- One natural sub-module: ustc_fan_slot_buf. It holds the NUM_IN-slot register array with write-at-index and set-end-at-index ports.
- The FSM and output register stay in the top module.

Test Plan:
- NUM_IN=8. Send rows 3,3,3,1,1,0,0,0 (data 1..8) with no stall. Expect one line, slot7..0 ctrl = 1010,1000,1001,1010,1001,1010,1000,1001, with rows/data in order. out_valid exactly one cycle after the 8th accept.
- NUM_IN=8. Send rows 2,2,5 then flush. Expect slots 7..5 ctrl = 1010,1001,1011, slots 4..0 = 0. in_ready stays 1 throughout.
- NUM_IN=8. Send 10 elements all row 4 with in_last on the 10th. Expect line A: slot7=1010, slots6..1=1000, slot0=1001. Line B: slot7=1010, slot6=1001, rest 0.
- out_ready=0: fill two full lines. Expect out holds line A stable, the second line sits in HOLD with in_ready=0. Raise out_ready: the cycle A drains, B loads, in_ready returns to 1 next cycle.
- Assert rst after 5 accepts. Expect out_valid=0, out=0, and no emission of those 5 elements. The next stream packs starting at slot NUM_IN-1.
- Default NUM_IN=32, alternating rows 0,1,0,1,... Expect every slot ctrl=1011.
